// File: rtl/vector_sequencer.sv
// Vector display command sequencer: a DEPTH-entry command FIFO feeding a jump/draw/frame-end
// strobe FSM with a post-strobe guard window. Define VECTOR_SEQ_OVF_EN to add a sticky overflow flag.
module vector_sequencer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned GUARD = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [25:0]              wr_data,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   input  logic                     ready,
   output logic [11:0]              x,
   output logic [11:0]              y,
   output logic                     jump,
   output logic                     draw,
   output logic                     frame_done
`ifdef VECTOR_SEQ_OVF_EN
   ,
   output logic                     overflow
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD) : 1;
   localparam logic [GW-1:0] GuardLast = GW'((GUARD > 0) ? GUARD - 1 : 0);
   localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

   localparam logic [1:0] OpJump  = 2'b00;
   localparam logic [1:0] OpDraw  = 2'b01;
   localparam logic [1:0] OpFrame = 2'b10;
   localparam logic [1:0] OpNop   = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StGuardWait,
      StReadyWait
   } state_e;

   state_e        state_q, state_d;
   logic [25:0]   mem [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q;
   logic [25:0]   rd_data;
   logic [1:0]    op_q;
   logic [11:0]   x_q, y_q;
   logic [GW-1:0] guard_cnt_q, guard_cnt_d;
   logic          empty, push, pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FullCount);
   assign level   = count_q;
   assign rd_data = mem[rptr_q];
   assign x       = x_q;
   assign y       = y_q;

   // A full FIFO still takes a write when the same cycle frees a slot.
   assign push = wr_en && (!full || pop);

   always_comb begin
      state_d     = state_q;
      guard_cnt_d = guard_cnt_q;
      pop         = 1'b0;
      jump        = 1'b0;
      draw        = 1'b0;
      frame_done  = 1'b0;
      case (state_q)
         StIdle: begin
            if (!empty && ready) begin
               pop     = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            case (op_q)
               OpJump, OpDraw: begin
                  jump        = (op_q == OpJump);
                  draw        = (op_q == OpDraw);
                  guard_cnt_d = '0;
                  state_d     = (GUARD == 0) ? StReadyWait : StGuardWait;
               end
               OpFrame: begin
                  frame_done = 1'b1;
                  state_d    = StIdle;
               end
               default: state_d = StIdle;
            endcase
         end
         StGuardWait: begin
            if (guard_cnt_q == GuardLast) begin
               state_d = StReadyWait;
            end else begin
               guard_cnt_d = guard_cnt_q + GW'(1);
            end
         end
         StReadyWait: begin
            if (ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // Reset in the issue cycle kills the strobe immediately, not one cycle late.
      if (!reset) begin
         jump       = 1'b0;
         draw       = 1'b0;
         frame_done = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StIdle;
         guard_cnt_q <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         op_q        <= OpNop;
         x_q         <= '0;
         y_q         <= '0;
      end else begin
         state_q     <= state_d;
         guard_cnt_q <= guard_cnt_d;
         if (push) begin
            wptr_q <= wptr_q + AW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + AW'(1);
            op_q   <= rd_data[25:24];
            // Coordinates only move for jump/draw; frame-end and nop keep the beam target.
            if (!rd_data[25]) begin
               x_q <= rd_data[23:12];
               y_q <= rd_data[11:0];
            end
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW + 1)'(1);
            2'b01:   count_q <= count_q - (AW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef VECTOR_SEQ_OVF_EN
   logic overflow_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         overflow_q <= 1'b0;
      end else if (wr_en && !push) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_vector_sequencer.sv
// Scoreboard bench for vector_sequencer: stimulus queues expected strobes, a negedge monitor
// pops and compares kind, coordinates, cycle and jump/draw spacing.
module tb_vector_sequencer;

   localparam int DEPTH = 16;
   localparam int GUARD = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wr_en = 1'b0;
   logic [25:0] wr_data = '0;
   logic        ready = 1'b0;
   logic        full;
   logic [4:0]  level;
   logic [11:0] x, y;
   logic        jump, draw, frame_done;
`ifdef VECTOR_SEQ_OVF_EN
   logic        overflow;
`endif

   vector_sequencer #(
      .DEPTH(DEPTH),
      .GUARD(GUARD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .level     (level),
      .ready     (ready),
      .x         (x),
      .y         (y),
      .jump      (jump),
      .draw      (draw),
      .frame_done(frame_done)
`ifdef VECTOR_SEQ_OVF_EN
      ,
      .overflow  (overflow)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  kind;
      logic [11:0] ex;
      logic [11:0] ey;
      int          at;
   } exp_t;

   exp_t        exp_q[$];
   logic [11:0] mx = '0;
   logic [11:0] my = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one accepted command and queue the strobe it should produce (at < 0: any cycle).
   task automatic push_cmd(input logic [1:0] op, input logic [11:0] px, input logic [11:0] py,
                           input int at);
      exp_t e;
      wr_en   = 1'b1;
      wr_data = {op, px, py};
      if (op == 2'b00 || op == 2'b01) begin
         mx = px;
         my = py;
         e  = '{op, px, py, at};
         exp_q.push_back(e);
      end else if (op == 2'b10) begin
         e = '{op, mx, my, at};
         exp_q.push_back(e);
      end
      tick();
      wr_en = 1'b0;
   endtask

   // Monitor: strobes are compared against the scoreboard away from the rising edge.
   exp_t       me;
   logic [1:0] mkind;
   int         last_mv = -1000;

   always @(negedge clk) begin
      if (int'(jump) + int'(draw) + int'(frame_done) > 1) begin
         checks++;
         failures++;
         $display("FAIL strobe_onehot: got jump=%b draw=%b frame_done=%b expected at most one",
                  jump, draw, frame_done);
      end else if (jump || draw || frame_done) begin
         mkind = jump ? 2'b00 : (draw ? 2'b01 : 2'b10);
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe: got kind=%0d x=%h y=%h at cycle %0d expected none",
                     mkind, x, y, cyc);
         end else begin
            me = exp_q.pop_front();
            if (mkind !== me.kind || x !== me.ex || y !== me.ey || (me.at >= 0 && cyc != me.at))
            begin
               failures++;
               $display("FAIL strobe: got kind=%0d x=%h y=%h cycle=%0d expected kind=%0d x=%h y=%h cycle=%0d",
                        mkind, x, y, cyc, me.kind, me.ex, me.ey, me.at);
            end
         end
         if (mkind != 2'b10) begin
            checks++;
            if (cyc - last_mv < GUARD + 3) begin
               failures++;
               $display("FAIL strobe_spacing: got %0d cycles expected >= %0d", cyc - last_mv,
                        GUARD + 3);
            end
            last_mv = cyc;
         end
      end
   end

   int c;

   initial begin
      // Reset state
      reset = 1'b0;
      ready = 1'b0;
      repeat (3) tick();
      check("reset_level", level, 0);
      check("reset_full", full, 0);
      check("reset_x", x, 0);
      check("reset_y", y, 0);
      check("reset_strobes", {jump, draw, frame_done}, 0);
`ifdef VECTOR_SEQ_OVF_EN
      check("reset_overflow", overflow, 0);
`endif
      reset = 1'b1;
      tick();

      // Single draw with ready high: strobe two cycles after the push
      ready = 1'b1;
      c = cyc;
      push_cmd(2'b01, 12'h123, 12'h456, c + 2);
      repeat (8) tick();
      check("draw_x_hold", x, 12'h123);
      check("draw_y_hold", y, 12'h456);
      check("draw_level", level, 0);

      // Jump then draw; ready low for 10 cycles after the jump strobe
      c = cyc;
      push_cmd(2'b00, 12'h0AA, 12'h0BB, c + 2);
      push_cmd(2'b01, 12'h321, 12'h654, c + 14);
      ready = 1'b0;
      repeat (10) tick();
      check("stall_level", level, 1);
      check("stall_x", x, 12'h0AA);
      check("stall_y", y, 12'h0BB);
      ready = 1'b1;
      repeat (8) tick();
      check("after_stall_x", x, 12'h321);

      // Frame end then nop: coordinates untouched
      c = cyc;
      push_cmd(2'b10, 12'hFFF, 12'hEEE, c + 2);
      push_cmd(2'b11, 12'hABC, 12'hDEF, -1);
      repeat (6) tick();
      check("frame_x", x, 12'h321);
      check("frame_y", y, 12'h654);
      check("frame_level", level, 0);

      // Fill to DEPTH with ready low, then one dropped write
      ready = 1'b0;
      for (int i = 0; i < 15; i++) push_cmd(2'b00, 12'(i), 12'(12'h100 + i), -1);
      check("fill15_level", level, 15);
      check("fill15_full", full, 0);
      push_cmd(2'b00, 12'd15, 12'h10F, -1);
      check("fill16_level", level, 16);
      check("fill16_full", full, 1);
      wr_en   = 1'b1;
      wr_data = {2'b00, 12'hDED, 12'hDED};
      tick();
      wr_en = 1'b0;
      check("drop_level", level, 16);
      check("drop_full", full, 1);
`ifdef VECTOR_SEQ_OVF_EN
      check("drop_overflow", overflow, 1);
`endif
      // Write while full is accepted when a pop happens in the same cycle
      ready = 1'b1;
      push_cmd(2'b00, 12'h010, 12'h110, -1);
      check("full_pushpop_level", level, 16);
      repeat (100) tick();
      check("drain_level", level, 0);
      check("drain_full", full, 0);
`ifdef VECTOR_SEQ_OVF_EN
      check("overflow_sticky", overflow, 1);
`endif

      // 40 commands streamed through: pointers wrap more than twice
      for (int i = 0; i < 40; i++) begin
         push_cmd((i % 4 == 3) ? 2'b10 : ((i % 2 == 1) ? 2'b01 : 2'b00),
                  12'(12'h200 + i), 12'(12'hC00 - i), -1);
         repeat (3) tick();
      end
      repeat (250) tick();
      check("wrap_level", level, 0);

      // Reset during the issue cycle of a draw
      ready   = 1'b1;
      wr_en   = 1'b1;
      wr_data = {2'b01, 12'h777, 12'h888};
      tick();
      wr_data = {2'b00, 12'h111, 12'h222};
      tick();
      wr_en = 1'b0;
      reset = 1'b0;
      #3;
      check("rst_issue_draw", draw, 0);
      tick();
      check("rst_issue_level", level, 0);
      check("rst_issue_full", full, 0);
      check("rst_issue_x", x, 0);
      check("rst_issue_y", y, 0);
`ifdef VECTOR_SEQ_OVF_EN
      check("rst_overflow", overflow, 0);
`endif
      reset = 1'b1;
      mx = '0;
      my = '0;
      repeat (10) tick();
      check("post_rst_level", level, 0);
      check("post_rst_x", x, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning command FIFO depth in entries (power of two, 4..64).
REQ-002 SHALL have parameter GUARD, default 2, meaning cycles after a jump/draw pulse during which ready is ignored.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  push wr_data into FIFO.
REQ-006 SHALL have port wr_data  input  26  [25:24] opcode (00 jump, 01 draw, 10 frame end, 11 nop), [23:12] x, [11:0] y.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-009 SHALL have port ready  input  1  downstream vector control ready.
REQ-010 SHALL have port x  output  12  target X coordinate.
REQ-011 SHALL have port y  output  12  target Y coordinate.
REQ-012 SHALL have port jump  output  1  one-cycle jump strobe.
REQ-013 SHALL have port draw  output  1  one-cycle draw strobe.
REQ-014 SHALL have port frame_done  output  1  one-cycle frame-end strobe.

Function
REQ-015 SHALL buffer commands in a DEPTH-entry circular FIFO; write pointer and read pointer wrap from DEPTH-1 to 0.
REQ-016 SHALL ignore wr_en while full=1, unless a pop occurs in the same cycle, in which case the write is accepted.
REQ-017 SHALL implement states IDLE, ISSUE, GUARD_WAIT, READY_WAIT.
REQ-018 SHALL, in IDLE with FIFO non-empty and ready=1, pop one entry and go to ISSUE the next cycle.
REQ-019 SHALL, in ISSUE, drive jump=1 (opcode 00) or draw=1 (opcode 01) for exactly one cycle, with x/y updated to the popped values in that same cycle, then enter GUARD_WAIT.
REQ-020 SHALL, in ISSUE with opcode 10, pulse frame_done for one cycle, leave x/y unchanged, and return to IDLE.
REQ-021 SHALL, in ISSUE with opcode 11, emit no strobe, leave x/y unchanged, and return to IDLE.
REQ-022 SHALL stay in GUARD_WAIT for exactly GUARD cycles, ignoring ready, then enter READY_WAIT.
REQ-023 SHALL leave READY_WAIT for IDLE on the first cycle with ready=1.
REQ-024 SHALL hold x/y stable from ISSUE until the next jump/draw ISSUE.
REQ-025 SHALL never assert more than one of jump/draw/frame_done in a cycle.
REQ-026 SHALL have a minimum spacing of GUARD+3 cycles between successive jump/draw strobes.
REQ-027 SHALL compute level as entries written minus entries popped; a simultaneous push and pop leaves level unchanged.

Reset
REQ-028 SHALL, while reset=0 at a clock edge, set state=IDLE, empty the FIFO (level=0, full=0), and set x=0, y=0, jump=0, draw=0, frame_done=0.
REQ-029 SHALL, on reset asserted mid-command, discard the command and suppress any pending strobe in the following cycle.

Configuration
REQ-030 SHALL, with VECTOR_SEQ_OVF_EN defined, add output overflow (1 bit); overflow sets sticky on any ignored write and clears only on reset.
REQ-031 SHALL, without VECTOR_SEQ_OVF_EN, omit the overflow port; dropped writes have no other effect.

Verification
REQ-032 SHALL cover: push draw(x=0x123, y=0x456) with ready=1 -> draw high one cycle, 2 cycles after push, with x=0x123, y=0x456.
REQ-033 SHALL cover: push jump then draw with ready held 0 after the jump pulse for 10 cycles -> no draw strobe until ready returns to 1, then draw 2 cycles later.
REQ-034 SHALL cover: 17 pushes with DEPTH=16 and ready=0 -> full=1, level=16, 17th write dropped; overflow=1 when VECTOR_SEQ_OVF_EN is defined.
REQ-035 SHALL cover: push frame end, then nop -> frame_done single pulse, no jump/draw, x/y unchanged.
REQ-036 SHALL cover: reset=0 in the ISSUE cycle of a draw -> no draw strobe, level=0, x=y=0.
REQ-037 SHALL cover: 40 push/pop cycles -> pointer wrap-around with data order preserved.
